// File: rtl/sw_led_pkg.sv
// Shared types and constants for the switch-to-LED controller.
package sw_led_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_INV  = 2'd1,
        MODE_ROT  = 2'd2,
        MODE_CNT  = 2'd3
    } mode_t;

    localparam int unsigned BLINK_TICKS = 8;

    // Number of bits needed to hold values 0..v-1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sw_led_ctrl_if.sv
// Board-facing signal bundle of sw_led_ctrl: raw switches/mode in, LEDs and debounced levels out.
interface sw_led_ctrl_if #(
    parameter int unsigned WIDTH = 12
);
    logic [WIDTH-1:0] SW;
    logic [1:0]       MODE;
    logic [WIDTH-1:0] LED;
    logic [WIDTH-1:0] SW_DEB;
    logic             CHG;

    modport master (
        output SW,
        output MODE,
        input  LED,
        input  SW_DEB,
        input  CHG
    );

    modport slave (
        input  SW,
        input  MODE,
        output LED,
        output SW_DEB,
        output CHG
    );
endinterface

// File: rtl/sw_debounce.sv
// One switch channel: SYNC_STAGES-flop synchroniser followed by a DEB_CYCLES stability filter.
module sw_debounce
    import sw_led_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_CYCLES  = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic take
);
    localparam int unsigned CW = clog2(DEB_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    // High on the edge where dout will adopt the new level; lets the parent register CHG alongside it.
    assign take = (synced != dout) && (cnt == CW'(DEB_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt    <= '0;
            dout   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            if (synced == dout) begin
                cnt <= '0;
            end else if (take) begin
                dout <= synced;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/sw_led_ctrl.sv
// Switch-to-LED controller: debounced switches drive LEDs in pass/invert/rotate/count modes.
// Optional macro SW_LED_BLINK_EN gates PASS/INV output with a slow blink phase.
module sw_led_ctrl
    import sw_led_pkg::*;
#(
    parameter int unsigned WIDTH       = 12,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_CYCLES  = 16,
    parameter int unsigned TICK_DIV    = 1000
) (
    input  logic         CLK,
    input  logic         RST_N,
    sw_led_ctrl_if.slave bus
);
    localparam int unsigned TW = clog2(TICK_DIV);

    logic [WIDTH-1:0]                deb;
    logic [WIDTH-1:0]                take;
    logic [SYNC_STAGES-1:0][1:0]     mode_sq;
    mode_t                           mode_s;
    mode_t                           mode_q;
    logic                            entry;
    logic [TW-1:0]                   tcnt;
    logic                            tick;
    logic [WIDTH-1:0]                pattern;
    logic [WIDTH-1:0]                count;
    logic [WIDTH-1:0]                led_next;
    logic [WIDTH-1:0]                led_q;
    logic                            chg_q;

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_deb
        sw_debounce #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEB_CYCLES  (DEB_CYCLES)
        ) u_deb (
            .clk   (CLK),
            .rst_n (RST_N),
            .din   (bus.SW[i]),
            .dout  (deb[i]),
            .take  (take[i])
        );
    end

    assign mode_s = mode_t'(mode_sq[SYNC_STAGES-1]);
    assign entry  = (mode_s != mode_q);
    assign tick   = !entry && (tcnt == TW'(TICK_DIV - 1));

`ifdef SW_LED_BLINK_EN
    localparam int unsigned BW = clog2(BLINK_TICKS);

    logic [BW-1:0] bcnt;
    logic          phase;

    // Runs independently of mode changes so the blink rhythm is continuous.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            bcnt  <= '0;
            phase <= 1'b0;
        end else if (tick) begin
            if (bcnt == BW'(BLINK_TICKS - 1)) begin
                bcnt  <= '0;
                phase <= ~phase;
            end else begin
                bcnt <= bcnt + BW'(1);
            end
        end
    end
`endif

    always_comb begin
        led_next = deb;
        case (mode_s)
            MODE_PASS: led_next = deb;
            MODE_INV:  led_next = ~deb;
            MODE_ROT:  led_next = pattern;
            MODE_CNT:  led_next = count;
            default:   led_next = deb;
        endcase
`ifdef SW_LED_BLINK_EN
        if ((mode_s == MODE_PASS || mode_s == MODE_INV) && !phase) begin
            led_next = '0;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            mode_sq <= '0;
            mode_q  <= MODE_PASS;
            tcnt    <= '0;
            pattern <= '0;
            count   <= '0;
            led_q   <= '0;
            chg_q   <= 1'b0;
        end else begin
            mode_sq <= {mode_sq[SYNC_STAGES-2:0], bus.MODE};
            mode_q  <= mode_s;
            chg_q   <= |take;
            led_q   <= led_next;

            if (entry || tcnt == TW'(TICK_DIV - 1)) begin
                tcnt <= '0;
            end else begin
                tcnt <= tcnt + TW'(1);
            end

            // chg_q marks the cycle in which deb already holds the new level, so loads use deb.
            case (mode_s)
                MODE_ROT: begin
                    if (entry || chg_q) begin
                        pattern <= deb;
                    end else if (tick) begin
                        pattern <= {pattern[WIDTH-2:0], pattern[WIDTH-1]};
                    end
                end
                MODE_CNT: begin
                    if (entry) begin
                        count <= '0;
                    end else if (chg_q) begin
                        count <= deb;
                    end else if (tick) begin
                        count <= count + WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.SW_DEB = deb;
    assign bus.LED    = led_q;
    assign bus.CHG    = chg_q;

endmodule

// File: tb/tb_sw_led_ctrl.sv
// Scoreboard bench for sw_led_ctrl: a behavioural model predicts each edge's outputs, a monitor compares.
module tb_sw_led_ctrl;

    localparam int W  = 12;
    localparam int S  = 2;
    localparam int D  = 4;
    localparam int TD = 5;
    localparam logic [W-1:0] MASK = '1;

    typedef struct {
        logic [W-1:0] led;
        logic [W-1:0] deb;
        logic         chg;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t q[$];
    int   checks;
    int   errors;
    int   cyc;

    sw_led_ctrl_if #(.WIDTH(W)) bus ();

    sw_led_ctrl #(
        .WIDTH       (W),
        .SYNC_STAGES (S),
        .DEB_CYCLES  (D),
        .TICK_DIV    (TD)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state, expressed in terms of observable behaviour.
    logic [W-1:0] swp [S];
    logic [1:0]   mp  [S];
    int           run [W];
    logic [W-1:0] m_deb, m_pat, m_cnt;
    logic         m_chg;
    logic [1:0]   m_mode_q;
    int           since;
    int           nticks;
    logic         phase;

    task automatic model_reset();
        for (int i = 0; i < S; i++) begin
            swp[i] = '0;
            mp[i]  = '0;
        end
        for (int i = 0; i < W; i++) run[i] = 0;
        m_deb = '0; m_pat = '0; m_cnt = '0; m_chg = 1'b0;
        m_mode_q = '0; since = 0; nticks = 0; phase = 1'b0;
    endtask

    task automatic model_step(input logic [W-1:0] sw, input logic [1:0] mode, input logic rn);
        exp_t         e;
        logic [W-1:0] synced, new_deb, led;
        logic [1:0]   ms;
        logic         any, entry, tick;
        if (!rn) begin
            model_reset();
            e.led = '0; e.deb = '0; e.chg = 1'b0;
            q.push_back(e);
            return;
        end
        synced  = swp[S-1];
        ms      = mp[S-1];
        new_deb = m_deb;
        any     = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (synced[i] != m_deb[i]) begin
                run[i]++;
                if (run[i] == D) begin
                    new_deb[i] = synced[i];
                    run[i] = 0;
                    any = 1'b1;
                end
            end else begin
                run[i] = 0;
            end
        end
        entry = (ms != m_mode_q);
        tick  = !entry && ((since % TD) == TD - 1);
        case (ms)
            2'd0:    led = m_deb;
            2'd1:    led = ~m_deb;
            2'd2:    led = m_pat;
            default: led = m_cnt;
        endcase
`ifdef SW_LED_BLINK_EN
        if (ms < 2 && !phase) led = '0;
        if (tick) begin
            nticks++;
            if (nticks % 8 == 0) phase = ~phase;
        end
`endif
        if (ms == 2'd2) begin
            if (entry || m_chg) m_pat = m_deb;
            else if (tick) m_pat = ((m_pat << 1) | (m_pat >> (W - 1))) & MASK;
        end else if (ms == 2'd3) begin
            if (entry) m_cnt = '0;
            else if (m_chg) m_cnt = m_deb;
            else if (tick) m_cnt = W'((32'(m_cnt) + 1) % (1 << W));
        end
        since = entry ? 0 : since + 1;
        for (int i = S - 1; i > 0; i--) begin
            swp[i] = swp[i-1];
            mp[i]  = mp[i-1];
        end
        swp[0]   = sw;
        mp[0]    = mode;
        m_mode_q = ms;
        m_chg    = any;
        m_deb    = new_deb;
        e.led = led; e.deb = new_deb; e.chg = any;
        q.push_back(e);
    endtask

    // Drive one set of inputs for n edges, predicting each edge.
    task automatic drive(input logic [W-1:0] sw, input logic [1:0] mode, input logic rn, input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #2;
            bus.SW   = sw;
            bus.MODE = mode;
            rst_n    = rn;
            model_step(sw, mode, rn);
        end
    endtask

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q.size() != 0) begin
                e = q.pop_front();
                check("sw_deb", bus.SW_DEB, e.deb);
                check("chg", W'(bus.CHG), W'(e.chg));
                check("led", bus.LED, e.led);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL timeout: stimulus did not complete");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [W-1:0] sw;
        logic [1:0]   mode;
        checks = 0; errors = 0; cyc = 0;
        rst_n = 1'b0; bus.SW = '1; bus.MODE = 2'd1;
        model_reset();

        drive(12'hFFF, 2'd1, 1'b0, 3);
        drive(12'hFFF, 2'd1, 1'b1, 10);
        drive(12'h000, 2'd0, 1'b1, 10);
        drive(12'h555, 2'd0, 1'b1, 10);
        drive(12'h554, 2'd0, 1'b1, 3);
        drive(12'h555, 2'd0, 1'b1, 10);
        drive(12'h554, 2'd0, 1'b1, 4);
        drive(12'h555, 2'd0, 1'b1, 10);
        drive(12'h555, 2'd1, 1'b1, 10);
        drive(12'h001, 2'd1, 1'b1, 10);
        drive(12'h001, 2'd2, 1'b1, 70);
        drive(12'h003, 2'd2, 1'b1, 20);
        drive(12'h003, 2'd3, 1'b1, 20);
        drive(12'hFFF, 2'd3, 1'b1, 15);
        // Step the change through every tick phase so a load coincides with a tick.
        for (int k = 0; k < TD; k++) begin
            drive(12'h100 + W'(k), 2'd3, 1'b1, 7 + k);
            drive(12'h200 + W'(k), 2'd2, 1'b1, 6 + k);
        end

        sw = 12'h0F0; mode = 2'd0;
        for (int seg = 0; seg < 300; seg++) begin
            if ($urandom_range(0, 79) == 0) begin
                drive(sw, mode, 1'b0, $urandom_range(1, 3));
            end
            if ($urandom_range(0, 5) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) sw = sw ^ (W'(1) << $urandom_range(0, W - 1));
            else sw = W'($urandom);
            drive(sw, mode, 1'b1, $urandom_range(1, 12));
        end

        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
